// File: rtl/arb2_req.sv
// Two-channel burst requester: each channel holds a request to a shared two-way
// arbiter for a programmed number of granted beats, with grant-wait timeout.

module arb2_req_chan #(
    parameter int LEN_W    = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             gnt,
    output logic             req,
    output logic             busy,
    output logic             done,
    output logic             tmo
);
    localparam int WCW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, OWN, DONE} state_t;

    state_t           state;
    logic [LEN_W-1:0] bcnt;
    logic [WCW-1:0]   wcnt;
    logic [WCW-1:0]   wcnt_inc;

    // wcnt stays below MAX_WAIT, so the increment never wraps.
    assign wcnt_inc = wcnt + 1'b1;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register in this block samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            bcnt  <= '0;
            wcnt  <= '0;
            req   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            tmo   <= 1'b0;
        end else begin
            done <= 1'b0;
            tmo  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= WAIT;
                        bcnt  <= (len == '0) ? LEN_W'(1) : len;
                        wcnt  <= '0;
                        req   <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                WAIT, OWN: begin
                    if (gnt) begin
                        bcnt <= bcnt - 1'b1;
                        if (bcnt == LEN_W'(1)) begin
                            state <= DONE;
                            req   <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= OWN;
                        end
                    end else if (state == OWN) begin
                        // Preempted: keep the remaining beats, restart the wait budget.
                        state <= WAIT;
                        wcnt  <= '0;
                    end else if (wcnt_inc == WCW'(MAX_WAIT)) begin
                        state <= IDLE;
                        wcnt  <= '0;
                        req   <= 1'b0;
                        busy  <= 1'b0;
                        tmo   <= 1'b1;
                    end else begin
                        wcnt <= wcnt_inc;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    req   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

module arb2_req #(
    parameter int LEN_W    = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start1,
    input  logic             start2,
    input  logic [LEN_W-1:0] len1,
    input  logic [LEN_W-1:0] len2,
    input  logic             gnt1,
    input  logic             gnt2,
    output logic             req1,
    output logic             req2,
    output logic             busy1,
    output logic             busy2,
    output logic             done1,
    output logic             done2,
    output logic             tmo1,
    output logic             tmo2,
    output logic             proto_err
);
    arb2_req_chan #(.LEN_W(LEN_W), .MAX_WAIT(MAX_WAIT)) u_ch1 (
        .clk(clk), .rst(rst), .start(start1), .len(len1), .gnt(gnt1),
        .req(req1), .busy(busy1), .done(done1), .tmo(tmo1)
    );

    arb2_req_chan #(.LEN_W(LEN_W), .MAX_WAIT(MAX_WAIT)) u_ch2 (
        .clk(clk), .rst(rst), .start(start2), .len(len2), .gnt(gnt2),
        .req(req2), .busy(busy2), .done(done2), .tmo(tmo2)
    );

    // Sticky flag for an arbiter that granted both channels at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            proto_err <= 1'b0;
        else if (gnt1 && gnt2)
            proto_err <= 1'b1;
    end
endmodule

// File: doc/arb2_req.md
ARB2_REQ -- requirements
Module: arb2_req

Interface
REQ-001 Parameter LEN_W, default 4, width of burst-length inputs and beat counters.
REQ-002 Parameter MAX_WAIT, default 15, grant-wait cycles before a channel times out (range 1..255).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  one clock; reset is asynchronous and active-low.
REQ-005 start1, start2  input  1 each  per-channel burst launch strobe.
REQ-006 len1, len2  input  LEN_W each  burst length in grant beats, sampled with start; 0 treated as 1.
REQ-007 gnt1, gnt2  input  1 each  grants from the two-way arbiter.
REQ-008 req1, req2  output  1 each  registered requests to the arbiter.
REQ-009 busy1, busy2  output  1 each  channel not IDLE.
REQ-010 done1, done2  output  1 each  one-cycle pulse on burst completion.
REQ-011 tmo1, tmo2  output  1 each  one-cycle pulse on grant-wait timeout.
REQ-012 proto_err  output  1  sticky: gnt1 and gnt2 both high on the same edge.

Function
REQ-013 Each channel SHALL run an independent FSM with states IDLE, WAIT, OWN, DONE; both channels identical.
REQ-014 IDLE: start high at edge -> WAIT; beat counter loaded with max(len,1); wait counter cleared.
REQ-015 start while not IDLE SHALL be ignored, with no effect on counters or outputs.
REQ-016 req SHALL be high in WAIT and OWN, low in IDLE and DONE; req rises the cycle after the start edge.
REQ-017 Beat = edge with channel in WAIT or OWN and its gnt high; each beat decrements the beat counter by 1.
REQ-018 WAIT: beat -> OWN (or DONE if counter was 1); no gnt -> wait counter +1.
REQ-019 WAIT: wait counter reaching MAX_WAIT with no gnt -> IDLE, tmo pulse the following cycle, req low.
REQ-020 OWN: beat with counter 1 -> DONE; beat with counter >1 -> stay OWN.
REQ-021 OWN: gnt low (preemption) -> WAIT, remaining count preserved, wait counter cleared.
REQ-022 DONE lasts exactly one cycle with done high, then IDLE; start SHALL NOT be accepted in DONE.
REQ-023 Burst of N beats with gnt held continuously: req high exactly N cycles, done in cycle N+1 after first beat.
REQ-024 Counters SHALL NOT wrap; wait counter width ceil(log2(MAX_WAIT+1)).
REQ-025 proto_err SHALL set on any edge with gnt1 and gnt2 both high, hold until reset; channel FSMs still act on their own gnt.
REQ-026 gnt high while the channel is IDLE or DONE SHALL be ignored.

Reset
REQ-027 rst low SHALL asynchronously force both FSMs to IDLE, all counters to 0, all outputs to 0, including proto_err.
REQ-028 rst asserted mid-burst SHALL abandon the burst with no done or tmo pulse; after release, channels accept start on the first edge.

Verification
REQ-029 start1 with len1=3, gnt1 held high from the cycle req1 rises -> req1 high 3 cycles, done1 one cycle, busy1 low after.
REQ-030 start2 with len2=4, gnt2 high 2 cycles, low 3, high 2 -> req2 stays high throughout, done2 after 4th beat, no tmo2.
REQ-031 start1 with len1=2, gnt1 never asserted, MAX_WAIT=15 -> req1 high 15 cycles, tmo1 pulse, req1 low, no done1.
REQ-032 start1 and start2 same edge, len 0 each, grants alternating one-hot -> each req high exactly one beat, one done each, proto_err stays 0.
REQ-033 gnt1 and gnt2 both high one cycle during a burst -> proto_err 1 and stays 1 until rst low; rst low mid-burst -> all outputs 0 immediately.
REQ-034 start1 repeated while busy1 -> ignored, beat count unchanged, single done1.
